// File: rtl/move_receiver.sv
// Per-square move collector: snapshots 16 move messages and streams accepted moves.
// Optional MOVE_COUNT_EN adds a move_count output that counts handshakes per scan.
module move_receiver #(
  parameter int SLIDE_W  = 11,
  parameter int KNIGHT_W = 8,
  parameter int POS_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  engine_color,
  input  logic [POS_W-1:0]      pos_reg,
  input  logic [5:0]            piece_reg,
  input  logic [8*SLIDE_W-1:0]  slide_moves,
  input  logic [8*KNIGHT_W-1:0] knight_moves,
  input  logic                  scan_start,
  output logic                  busy,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [POS_W-1:0]      move_from,
  output logic [POS_W-1:0]      move_to,
  output logic                  move_capture,
  output logic [3:0]            move_dir,
  output logic                  scan_done
`ifdef MOVE_COUNT_EN
  ,
  output logic [4:0]            move_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;

  logic [8*SLIDE_W-1:0]  snap_slide_q, snap_slide_d;
  logic [8*KNIGHT_W-1:0] snap_knight_q, snap_knight_d;
  logic [5:0]            snap_piece_q, snap_piece_d;
  logic [POS_W-1:0]      snap_pos_q, snap_pos_d;
  logic                  snap_color_q, snap_color_d;

  logic [POS_W-1:0] from_q, from_d;
  logic [POS_W-1:0] to_q, to_d;
  logic [3:0]       dir_q, dir_d;
  logic             cap_q, cap_d;

`ifdef MOVE_COUNT_EN
  logic [4:0] cnt_q, cnt_d;
`endif

  logic [SLIDE_W-1:0]  slide_arr [8];
  logic [KNIGHT_W-1:0] knight_arr [8];

  for (genvar k = 0; k < 8; k++) begin : g_unpack
    assign slide_arr[k]  = snap_slide_q[k*SLIDE_W +: SLIDE_W];
    assign knight_arr[k] = snap_knight_q[k*KNIGHT_W +: KNIGHT_W];
  end

  logic [SLIDE_W-1:0]  slide_sel;
  logic [KNIGHT_W-1:0] knight_sel;
  logic                msg_nz;
  logic                msg_col;
  logic [POS_W-1:0]    msg_from;
  logic                piece_occ;
  logic                accept;

  assign slide_sel  = slide_arr[idx_q[2:0]];
  assign knight_sel = knight_arr[idx_q[2:0]];
  assign piece_occ  = |snap_piece_q;

  always_comb begin
    msg_nz   = 1'b0;
    msg_col  = 1'b0;
    msg_from = '0;
    unique case (1'b1)
      idx_q[3]: begin
        msg_nz   = |knight_sel;
        msg_col  = knight_sel[KNIGHT_W-1];
        msg_from = knight_sel[POS_W-1:0];
      end
      default: begin
        msg_nz   = |slide_sel;
        msg_col  = slide_sel[SLIDE_W-1];
        msg_from = slide_sel[POS_W-1:0];
      end
    endcase
  end

  // Same-colour occupant is dropped even if the sender got it wrong.
  assign accept = msg_nz
                && (msg_col == snap_color_q)
                && !(piece_occ && (snap_piece_q[5] == msg_col));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_slide_d  = snap_slide_q;
    snap_knight_d = snap_knight_q;
    snap_piece_d  = snap_piece_q;
    snap_pos_d    = snap_pos_q;
    snap_color_d  = snap_color_q;
    from_d        = from_q;
    to_d          = to_q;
    dir_d         = dir_q;
    cap_d         = cap_q;
`ifdef MOVE_COUNT_EN
    cnt_d         = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          snap_slide_d  = slide_moves;
          snap_knight_d = knight_moves;
          snap_piece_d  = piece_reg;
          snap_pos_d    = pos_reg;
          snap_color_d  = engine_color;
          idx_d         = '0;
          state_d       = S_SCAN;
`ifdef MOVE_COUNT_EN
          cnt_d         = '0;
`endif
        end
      end
      S_SCAN: begin
        if (accept) begin
          from_d  = msg_from;
          to_d    = snap_pos_q;
          dir_d   = idx_q;
          cap_d   = piece_occ;
          state_d = S_EMIT;
        end else if (idx_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_EMIT: begin
        if (move_ready) begin
`ifdef MOVE_COUNT_EN
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
`endif
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      snap_slide_q  <= '0;
      snap_knight_q <= '0;
      snap_piece_q  <= '0;
      snap_pos_q    <= '0;
      snap_color_q  <= 1'b0;
      from_q        <= '0;
      to_q          <= '0;
      dir_q         <= '0;
      cap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_slide_q  <= snap_slide_d;
      snap_knight_q <= snap_knight_d;
      snap_piece_q  <= snap_piece_d;
      snap_pos_q    <= snap_pos_d;
      snap_color_q  <= snap_color_d;
      from_q        <= from_d;
      to_q          <= to_d;
      dir_q         <= dir_d;
      cap_q         <= cap_d;
    end
  end

`ifdef MOVE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign move_count = cnt_q;
`endif

  // Status outputs decode straight from state so reset clears them at once.
  assign busy         = (state_q != S_IDLE);
  assign move_valid   = (state_q == S_EMIT);
  assign scan_done    = (state_q == S_DONE);
  assign move_from    = from_q;
  assign move_to      = to_q;
  assign move_dir     = dir_q;
  assign move_capture = cap_q & (state_q == S_EMIT) | cap_q & (state_q != S_EMIT);

endmodule
